// File: rtl/qam_mapper_param_pkg.sv
//==============================================================================
// Module      : qam_mapper_param_pkg
// Description : Shared mode encodings, bits-per-dimension lookup and 16-QAM
//               field layout for the square-QAM symbol mapper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package qam_mapper_param_pkg;

    typedef enum logic [1:0] {
        QAM_MODE_QPSK = 2'd0,
        QAM_MODE_16   = 2'd1,
        QAM_MODE_64   = 2'd2,
        QAM_MODE_RSVD = 2'd3
    } qam_mode_e;

    // 16-QAM symbol layout: in-phase in the low pair, quadrature in the high pair
    localparam int INPHASE_LSB    = 0;
    localparam int INPHASE_MSB    = 1;
    localparam int QUADRATURE_LSB = 2;
    localparam int QUADRATURE_MSB = 3;

    typedef struct packed {
        logic [1:0] quadrature;
        logic [1:0] inphase;
    } qam16_sym_t;

    // Returns 0 for the reserved encoding so callers can flag it
    function automatic logic [1:0] bits_per_dim(input logic [1:0] mode);
        logic [1:0] n;
        case (qam_mode_e'(mode))
            QAM_MODE_QPSK: n = 2'd1;
            QAM_MODE_16:   n = 2'd2;
            QAM_MODE_64:   n = 2'd3;
            default:       n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/qam_mapper_param_if.sv
//==============================================================================
// Module      : qam_mapper_param_if
// Description : Symbol input / amplitude output bundle of the QAM mapper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface qam_mapper_param_if #(
    parameter int WIDTH   = 18,
    parameter int MAX_BPD = 3
);
    logic                      in_valid;
    logic [2*MAX_BPD-1:0]      data;
    logic [1:0]                mode;
    logic signed [WIDTH-1:0]   ref_level;
    logic                      out_valid;
    logic signed [WIDTH-1:0]   sig_inph;
    logic signed [WIDTH-1:0]   sig_quad;
    logic                      mode_err;
    logic                      sat_seen;

    modport master (
        output in_valid, data, mode, ref_level,
        input  out_valid, sig_inph, sig_quad, mode_err, sat_seen
    );

    modport slave (
        input  in_valid, data, mode, ref_level,
        output out_valid, sig_inph, sig_quad, mode_err, sat_seen
    );
endinterface

`default_nettype wire

// File: rtl/qam_level_gen.sv
//==============================================================================
// Module      : qam_level_gen
// Description : One dimension of the mapper: Gray decode and multiplier-less
//               (L-1-2b)*half. Clamps when QAM_MAPPER_SAT_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module qam_level_gen
    import qam_mapper_param_pkg::*;
#(
    parameter int WIDTH   = 18,
    parameter int MAX_BPD = 3
) (
    input  wire logic [1:0]              n_bits,
    input  wire logic [MAX_BPD-1:0]      gray,
    input  wire logic signed [WIDTH-1:0] half,
    output logic signed [WIDTH-1:0]      level,
    output logic                         sat
);

    localparam int c_ext_w = WIDTH + 4;
    localparam logic signed [c_ext_w-1:0] c_pos_max = {5'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [c_ext_w-1:0] c_neg_max = -c_pos_max;

    logic [MAX_BPD-1:0]         w_bin;
    logic                       w_par;
    logic signed [c_ext_w-1:0]  w_half_ext;
    logic signed [c_ext_w-1:0]  w_acc;

    // Bits at or above n_bits are outside the field and decode to 0
    always_comb begin
        w_par = 1'b0;
        w_bin = '0;
        for (int k = MAX_BPD - 1; k >= 0; k--) begin
            if (k < int'(n_bits)) begin
                w_par    = w_par ^ gray[k];
                w_bin[k] = w_par;
            end
        end
    end

    assign w_half_ext = c_ext_w'(half);

    always_comb begin
        w_acc = (w_half_ext <<< n_bits) - w_half_ext;
        for (int k = 0; k < MAX_BPD; k++) begin
            if (w_bin[k]) begin
                w_acc = w_acc - (w_half_ext <<< (k + 1));
            end
        end
        if (n_bits == 2'd0) begin
            w_acc = '0;
        end
    end

`ifdef QAM_MAPPER_SAT_EN
    always_comb begin
        level = w_acc[WIDTH-1:0];
        sat   = 1'b0;
        if (w_acc > c_pos_max) begin
            level = c_pos_max[WIDTH-1:0];
            sat   = 1'b1;
        end else if (w_acc < c_neg_max) begin
            level = c_neg_max[WIDTH-1:0];
            sat   = 1'b1;
        end
    end
`else
    logic w_unused_msbs;
    assign w_unused_msbs = ^{w_acc[c_ext_w-1:WIDTH], c_pos_max, c_neg_max};
    assign level = w_acc[WIDTH-1:0];
    assign sat   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/qam_mapper_param.sv
//==============================================================================
// Module      : qam_mapper_param
// Description : Two-stage pipelined QPSK/16/64-QAM Gray mapper with clk_en.
//               Optional output clamp via QAM_MAPPER_SAT_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module qam_mapper_param
    import qam_mapper_param_pkg::*;
#(
    parameter int WIDTH   = 18,
    parameter int MAX_BPD = 3
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          clk_en,
    qam_mapper_param_if.slave  bus
);

    logic [1:0]              w_bpd;
    logic                    w_mode_bad;
    logic [1:0]              w_n_bits;
    logic [MAX_BPD-1:0]      w_gray_i;
    logic [MAX_BPD-1:0]      w_gray_q;
    logic signed [WIDTH-1:0] w_half;

    logic                    r1_valid;
    logic                    r1_mode_bad;
    logic [1:0]              r1_n_bits;
    logic [MAX_BPD-1:0]      r1_gray_i;
    logic [MAX_BPD-1:0]      r1_gray_q;
    logic signed [WIDTH-1:0] r1_half;

    logic signed [WIDTH-1:0] w_lvl_i;
    logic signed [WIDTH-1:0] w_lvl_q;
    logic                    w_sat_i;
    logic                    w_sat_q;

    logic                    r2_valid;
    logic signed [WIDTH-1:0] r2_inph;
    logic signed [WIDTH-1:0] r2_quad;
    logic                    r_mode_err;

    // A bad mode is carried as n_bits=0, which the level generators map to 0
    always_comb begin
        w_bpd      = bits_per_dim(bus.mode);
        w_mode_bad = (w_bpd == 2'd0) || (int'(w_bpd) > MAX_BPD);
        w_n_bits   = w_mode_bad ? 2'd0 : w_bpd;
        w_gray_i   = bus.data[MAX_BPD-1:0];
        w_gray_q   = MAX_BPD'(bus.data >> w_n_bits);
        w_half     = bus.ref_level >>> 1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r1_valid    <= 1'b0;
            r1_mode_bad <= 1'b0;
            r1_n_bits   <= '0;
            r1_gray_i   <= '0;
            r1_gray_q   <= '0;
            r1_half     <= '0;
        end else if (clk_en) begin
            r1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r1_mode_bad <= w_mode_bad;
                r1_n_bits   <= w_n_bits;
                r1_gray_i   <= w_gray_i;
                r1_gray_q   <= w_gray_q;
                r1_half     <= w_half;
            end
        end
    end

    qam_level_gen #(.WIDTH(WIDTH), .MAX_BPD(MAX_BPD)) u_level_i (
        .n_bits (r1_n_bits),
        .gray   (r1_gray_i),
        .half   (r1_half),
        .level  (w_lvl_i),
        .sat    (w_sat_i)
    );

    qam_level_gen #(.WIDTH(WIDTH), .MAX_BPD(MAX_BPD)) u_level_q (
        .n_bits (r1_n_bits),
        .gray   (r1_gray_q),
        .half   (r1_half),
        .level  (w_lvl_q),
        .sat    (w_sat_q)
    );

    // Outputs only load on a valid symbol so they hold between symbols
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r2_valid   <= 1'b0;
            r2_inph    <= '0;
            r2_quad    <= '0;
            r_mode_err <= 1'b0;
        end else if (clk_en) begin
            r2_valid <= r1_valid;
            if (r1_valid) begin
                r2_inph <= w_lvl_i;
                r2_quad <= w_lvl_q;
                if (r1_mode_bad) begin
                    r_mode_err <= 1'b1;
                end
            end
        end
    end

`ifdef QAM_MAPPER_SAT_EN
    logic r_sat_seen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sat_seen <= 1'b0;
        end else if (clk_en && r1_valid && (w_sat_i || w_sat_q)) begin
            r_sat_seen <= 1'b1;
        end
    end

    assign bus.sat_seen = r_sat_seen;
`else
    logic w_unused_sat;
    assign w_unused_sat = w_sat_i | w_sat_q;
    assign bus.sat_seen = 1'b0;
`endif

    assign bus.out_valid = r2_valid;
    assign bus.sig_inph  = r2_inph;
    assign bus.sig_quad  = r2_quad;
    assign bus.mode_err  = r_mode_err;

endmodule

`default_nettype wire

// File: doc/qam_mapper_param.md
Name: qam_mapper_param

Overview:
- Parametrised, pipelined square-QAM symbol mapper. Supports QPSK, 16-QAM and 64-QAM, selectable per symbol at run time.
- Maps Gray-coded symbol bits to signed I/Q amplitudes. Amplitudes are odd multiples of half the reference level, produced by a multiplier-less shift-add.
- Sits between the symbol/bit source and the pulse-shaping filter. Carries a valid qualifier through a 2-stage pipeline gated by clk_en.

Parameters:
- WIDTH, 18, signed width of ref_level, sig_inph and sig_quad.
- MAX_BPD, 3, maximum bits per dimension (3 gives 64-QAM). Sets the data port width to 2*MAX_BPD. Legal range 1..3.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clk_en  in  1  symbol-rate enable; all registers hold when low
- in_valid  in  1  data/mode/ref_level are valid this enabled cycle
- data  in  2*MAX_BPD  symbol bits; I = data[n-1:0], Q = data[2n-1:n] for n bits/dim; upper bits ignored
- mode  in  2  0=QPSK (n=1), 1=16-QAM (n=2), 2=64-QAM (n=3), 3=reserved
- ref_level  in  WIDTH  signed reference level, sampled per symbol
- out_valid  out  1  sig_inph/sig_quad hold a new symbol
- sig_inph  out  WIDTH  signed in-phase amplitude
- sig_quad  out  WIDTH  signed quadrature amplitude
- mode_err  out  1  sticky; set on an accepted reserved/unsupported mode
- sat_seen  out  1  sticky saturation flag (only with QAM_MAPPER_SAT_EN, else tied 0)

Behaviour:
- Reset is asynchronous on reset_n low. All outputs and pipeline registers go to 0: out_valid=0, sig_inph=0, sig_quad=0, mode_err=0, sat_seen=0. Reset mid-stream discards in-flight symbols.
- All state advances only on clk rising edges with clk_en=1. With clk_en=0, everything holds, including out_valid.
- Stage 1 (accept cycle, in_valid=1):
  - register the I/Q Gray fields, mode and half = ref_level >>> 1 (arithmetic shift);
  - Gray-to-binary convert each field: b[n-1]=g[n-1], b[k]=b[k+1]^g[k].
- Stage 2:
  - L = 2^n; coefficient c = (L-1) - 2*b, an odd value in [-(L-1), L-1];
  - amplitude = c * half, computed by shift-add in WIDTH+4 bits, then reduced to WIDTH;
  - register to sig_inph/sig_quad.
- Latency: 2 enabled cycles from in_valid to out_valid. Throughput is 1 symbol per enabled cycle. out_valid is in_valid delayed by 2 enabled cycles.
- sig_inph/sig_quad hold their last value while out_valid=0.
- 16-QAM level mapping per dimension: Gray 00→+3h, 01→+1h, 11→-1h, 10→-3h. This preserves the established 16-QAM constellation.
- Reserved mode (3), or a mode whose n > MAX_BPD:
  - the symbol still propagates with out_valid=1;
  - both outputs are 0;
  - mode_err is set and stays set until reset.
- Mode or ref_level may change on any symbol; each symbol uses the values sampled with it. There are no glitches across a mode change.
- Negative ref_level is legal; the constellation is inverted. half uses arithmetic shift, so ref_level=-1 gives half=-1.
- Overflow without the macro: two's-complement truncation to WIDTH bits (wrap).

Optional Feature:
- Macro: QAM_MAPPER_SAT_EN.
- Defined: stage-2 results outside [-(2^(WIDTH-1)-1), 2^(WIDTH-1)-1] clamp to the nearest bound (symmetric; the most-negative code is never emitted). sat_seen sets on any clamp, stays set until reset, and updates with the output register.
- Undefined: results wrap and sat_seen is constant 0.

Decomposition:
- Shared package/header holds:
  - mode encodings (QAM_MODE_QPSK=0, QAM_MODE_16=1, QAM_MODE_64=2);
  - a bits-per-dim lookup from mode;
  - the INPHASE/QUADRATURE field definitions for 16-QAM.
- One sub-module, qam_level_gen: a per-dimension Gray decode plus coefficient × half shift-add with optional clamp. Instantiated twice (I and Q). Purely combinational, registered by the parent.

Test Plan:
- Reset: hold reset_n=0 with random inputs and clk_en=1 → all outputs 0. Deassert, and the first out_valid appears exactly 2 enabled cycles after the first in_valid.
- 16-QAM sweep: ref_level=65536, mode=1, data=4'b1101 → sig_inph=+32768, sig_quad=-32768. data=4'b1000 → I=+98304, Q=-98304. All 16 points match the Gray table.
- 64-QAM: ref_level=16384, mode=2, data=6'b011_000 → I=+57344, Q=+24576. data I field 3'b100 → I=-57344.
- clk_en gating: toggle clk_en 1/0 every cycle with back-to-back in_valid → outputs change only on enabled edges. Order is preserved and out_valid is never duplicated.
- Saturation (WIDTH=18, macro on): ref_level=65536, mode=2, I field 3'b000 → 7×32768 clamps to +131071 and sat_seen=1. Macro off → wrapped value, sat_seen=0.
- Mode error: mode=3 with in_valid → out_valid=1, I=Q=0, mode_err=1 sticky. A following valid 16-QAM symbol maps correctly while mode_err stays 1.
